alu_sequencer: RTL
==================

# alu_sequencer

- Upstream control stage for the 16-bit ALU.
- Accepts one operation request (opcode plus two operands) over a valid/ready handshake.
- Drives the ALU's shared data bus, its two parameter-load enables, its opcode and its output enable in the required cycle order.
- Captures the ALU result and returns it on a valid/ready response port with zero and error flags.

## Interface
- DATA_WIDTH, 16, operand/result width; must equal the ALU data width (16).
- clock  input  1  single clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_opcode  input  3  ALU opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 xnor, 111 illegal.
- req_operand_a  input  DATA_WIDTH  first operand.
- req_operand_b  input  DATA_WIDTH  second operand; ignored for not.
- bus_out  output  DATA_WIDTH  connects to the ALU data input.
- enable_param_1  output  1  ALU first-parameter load enable.
- enable_param_2  output  1  ALU second-parameter load enable.
- enable_out  output  1  ALU output enable.
- opcode  output  3  ALU opcode.
- alu_result_in  input  DATA_WIDTH  connects to the ALU output; high-Z except after an enable_out cycle.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  DATA_WIDTH  captured result.
- resp_zero  output  1  resp_data equals 0.
- resp_error  output  1  request carried the illegal opcode 111.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP.
- All ALU-side outputs are decoded from the state only (Moore).
- Request fields are latched into internal registers on the accept edge; the request port is never re-read mid-operation.
- **IDLE**
  - req_ready=1.
  - On req_valid at an edge: latch opcode and operands.
  - Next state is LOAD_A, or RESP if opcode=111. For 111: resp_data=0, resp_error=1, resp_zero=0.
- **LOAD_A**: bus_out=operand_a, enable_param_1=1. Next state LOAD_B, or EXEC for opcode 010 (not).
- **LOAD_B**: bus_out=operand_b, enable_param_2=1. Next state EXEC.
- **EXEC**: enable_out=1, opcode=latched opcode. Next state CAPTURE.
- **CAPTURE**
  - alu_result_in is valid this cycle.
  - On the closing edge: resp_data<=alu_result_in, resp_zero<=(alu_result_in==0), resp_error<=0.
  - Next state RESP.
- **RESP**: resp_valid=1, held with resp_data and flags stable until resp_ready=1 at an edge. Next state IDLE.
- Outside their active state:
  - bus_out=0.
  - enable_param_1, enable_param_2 and enable_out are 0.
  - opcode=000.
- Only one enable is ever high in any cycle.
- req_ready=0 in every state except IDLE.
- Arithmetic is performed only by the ALU; results wrap mod 2^16 with no carry or borrow output.
- Reset values (all outputs): req_ready=1 (state IDLE), resp_valid=0, resp_data=0, resp_zero=0, resp_error=0, bus_out=0, all enables=0, opcode=000.
- Reset mid-operation: reset in any state returns to IDLE on that edge and drops any in-flight request with no response.

## Timing
- Accept edge E0 means req_valid=req_ready=1 at edge E0.
- Binary operations:
  - LOAD_A in cycle 1, LOAD_B in cycle 2, EXEC in cycle 3, CAPTURE in cycle 4.
  - resp_valid=1 from cycle 5, i.e. 5 edges after E0.
- Not: LOAD_B is skipped, so resp_valid=1 from cycle 4.
- Illegal opcode: resp_valid=1 from cycle 1; no ALU enables are asserted.
- Response handshake:
  - If resp_ready=1 in the first RESP cycle, the response completes in that cycle.
  - req_ready returns to 1 in the next cycle.
  - Throughput is at most one binary operation per 6 cycles.
- Operand bus:
  - bus_out is stable for the whole cycle in which its enable is high.
  - The ALU samples it at that cycle's closing edge.

## Test plan
- Add 0x1234 + 0x0101:
  - enable_param_1 pulses in cycle 1 and enable_param_2 in cycle 2 with the correct bus_out values; enable_out in cycle 3.
  - resp_valid in cycle 5 with resp_data=0x1335, resp_zero=0.
- Sub 0x0000 − 0x0001: resp_data=0xFFFF (wrap). Xor 0xA5A5 ^ 0xA5A5: resp_data=0x0000, resp_zero=1.
- Not 0x00FF (operand_b=0xBEEF):
  - enable_param_2 never asserted.
  - resp_data=0xFF00 with resp_valid in cycle 4.
- Opcode 111: no enables asserted; resp_valid in cycle 1 with resp_error=1, resp_data=0.
- Backpressure: resp_ready held low 3 cycles during RESP.
  - resp_valid and resp_data remain stable; req_ready=0 throughout; a pending req_valid is not accepted.
  - After resp_ready=1, req_ready=1 in the next cycle.
- Reset asserted during LOAD_B:
  - Next cycle is IDLE with all outputs at reset values; resp_valid never asserted for the dropped request.
  - A following add 3+4 returns 7.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one request through the 16-bit ALU (load A, load B, exec, capture)
// and returns the result on a valid/ready response port.
module alu_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_opcode,
    input  logic [DATA_WIDTH-1:0] req_operand_a,
    input  logic [DATA_WIDTH-1:0] req_operand_b,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  enable_param_1,
    output logic                  enable_param_2,
    output logic                  enable_out,
    output logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_zero,
    output logic                  resp_error
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP} state_t;
    state_t state;
    logic [2:0] op_q;
    logic [DATA_WIDTH-1:0] b_q;
    // Outputs are registered against the next state so they always match the current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            req_ready <= 1'b1;
            bus_out <= '0;
            enable_param_1 <= 1'b0;
            enable_param_2 <= 1'b0;
            enable_out <= 1'b0;
            opcode <= 3'b000;
            resp_valid <= 1'b0;
            resp_data <= '0;
            resp_zero <= 1'b0;
            resp_error <= 1'b0;
            op_q <= 3'b000;
            b_q <= '0;
        end else begin
            bus_out <= '0;
            enable_param_1 <= 1'b0;
            enable_param_2 <= 1'b0;
            enable_out <= 1'b0;
            opcode <= 3'b000;
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= req_opcode;
                    b_q <= req_operand_b;
                    req_ready <= 1'b0;
                    if (req_opcode == 3'b111) begin
                        state <= RESP;
                        resp_valid <= 1'b1;
                        resp_data <= '0;
                        resp_zero <= 1'b0;
                        resp_error <= 1'b1;
                    end else begin
                        state <= LOAD_A;
                        bus_out <= req_operand_a;
                        enable_param_1 <= 1'b1;
                    end
                end
                LOAD_A: if (op_q == 3'b010) begin
                    state <= EXEC;
                    enable_out <= 1'b1;
                    opcode <= op_q;
                end else begin
                    state <= LOAD_B;
                    bus_out <= b_q;
                    enable_param_2 <= 1'b1;
                end
                LOAD_B: begin
                    state <= EXEC;
                    enable_out <= 1'b1;
                    opcode <= op_q;
                end
                EXEC: state <= CAPTURE;
                CAPTURE: begin
                    state <= RESP;
                    resp_valid <= 1'b1;
                    resp_data <= alu_result_in;
                    resp_zero <= alu_result_in == '0;
                    resp_error <= 1'b0;
                end
                RESP: if (resp_ready) begin
                    state <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
